// File: rtl/universal_shift_register_engine.sv
// ============================================================================
// Module   : universal_shift_register_engine
// Brief    : Parametrised universal shift register (load, SHL/SHR/ROL/ROR/ASR, serial in/out)
//            with a one-bit-per-clock multi-cycle shift engine. Optional macro:
//            USR_TRISTATE_OUTPUT_EN (data outputs go to Z while Enable_In is low).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_register_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [2:0]       Mode_In,
  input  logic             Start_In,
  input  logic [CNT_W-1:0] Shift_Count_In,
  input  logic             Serial_Left_In,
  input  logic             Serial_Right_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Left_Out,
  output logic             Serial_Right_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] reg_q,   reg_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [2:0]       mode_q,  mode_d;
  logic [0:0]       state_q, state_d;
  logic             done_q,  done_d;

  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] val,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] load
  );
    logic [WIDTH-1:0] res;
    res = val;
    case (mode)
      MODE_LOAD: res = load;
      MODE_SHL:  res = {val[WIDTH-2:0], sr};
      MODE_SHR:  res = {sl, val[WIDTH-1:1]};
      MODE_ROL:  res = {val[WIDTH-2:0], val[WIDTH-1]};
      MODE_ROR:  res = {val[0], val[WIDTH-1:1]};
      MODE_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
      default:   res = val;
    endcase
    return res;
  endfunction

  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

  always_comb begin
    reg_d   = reg_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          if (Start_In && is_shift_mode(Mode_In)) begin
            if (Shift_Count_In == CNT_ZERO) begin
              done_d = 1'b1;
            end else begin
              reg_d = step_op(Mode_In, reg_q, Serial_Left_In, Serial_Right_In, Parallel_Data_In);
              if (Shift_Count_In == CNT_ONE) begin
                done_d = 1'b1;
              end else begin
                rem_d   = Shift_Count_In - CNT_ONE;
                mode_d  = Mode_In;
                state_d = ST_SHIFT;
              end
            end
          end else begin
            reg_d  = step_op(Mode_In, reg_q, Serial_Left_In, Serial_Right_In, Parallel_Data_In);
            done_d = Start_In;
          end
        end
        default: begin
          // Mode and load inputs are deliberately unused here: a running shift cannot be preempted.
          reg_d = step_op(mode_q, reg_q, Serial_Left_In, Serial_Right_In, reg_q);
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      reg_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign Busy_Out = (state_q == ST_SHIFT);
  assign Done_Out = done_q & Enable_In;

`ifdef USR_TRISTATE_OUTPUT_EN
  assign Parallel_Data_Out = Enable_In ? reg_q : {WIDTH{1'bz}};
  assign Serial_Left_Out   = Enable_In ? reg_q[WIDTH-1] : 1'bz;
  assign Serial_Right_Out  = Enable_In ? reg_q[0] : 1'bz;
`else
  assign Parallel_Data_Out = reg_q;
  assign Serial_Left_Out   = reg_q[WIDTH-1];
  assign Serial_Right_Out  = reg_q[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register_engine.sv
// ============================================================================
// Module   : tb_universal_shift_register_engine
// Brief    : Directed self-checking bench for universal_shift_register_engine (WIDTH=8, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_register_engine;

  logic       Clk_In = 1'b1;
  logic       Reset_In = 1'b1;
  logic       Enable_In = 1'b1;
  logic [2:0] Mode_In = 3'b000;
  logic       Start_In = 1'b0;
  logic [3:0] Shift_Count_In = 4'd0;
  logic       Serial_Left_In = 1'b0;
  logic       Serial_Right_In = 1'b0;
  logic [7:0] Parallel_Data_In = 8'h00;
  logic [7:0] Parallel_Data_Out;
  logic       Serial_Left_Out;
  logic       Serial_Right_Out;
  logic       Busy_Out;
  logic       Done_Out;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, RSVD = 3'b111;

  universal_shift_register_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Enable_In(Enable_In), .Mode_In(Mode_In),
    .Start_In(Start_In), .Shift_Count_In(Shift_Count_In), .Serial_Left_In(Serial_Left_In),
    .Serial_Right_In(Serial_Right_In), .Parallel_Data_In(Parallel_Data_In),
    .Parallel_Data_Out(Parallel_Data_Out), .Serial_Left_Out(Serial_Left_Out),
    .Serial_Right_Out(Serial_Right_Out), .Busy_Out(Busy_Out), .Done_Out(Done_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // {data, msb tap, lsb tap, busy, done}
  function automatic logic [11:0] obs();
    return {Parallel_Data_Out, Serial_Left_Out, Serial_Right_Out, Busy_Out, Done_Out};
  endfunction

  task automatic edge_();
    @(negedge Clk_In);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset_async got %h exp %h", obs(), 12'h000); end
    Mode_In = LOAD; Parallel_Data_In = 8'hFF;
    edge_();
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset_held got %h exp %h", obs(), 12'h000); end
    Reset_In = 1'b0; Parallel_Data_In = 8'hA5;
    edge_();
    checks++;
    if (obs() !== {8'hA5, 1'b1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL load_a5 got %h exp %h", obs(), {8'hA5, 4'b1100}); end
  endtask

  task automatic test_shl3();
    logic [11:0] e;
    Start_In = 1'b1; Mode_In = SHL; Shift_Count_In = 4'd3; Serial_Right_In = 1'b1;
    edge_();
    e = {8'h4B, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL shl3_e1 got %h exp %h", obs(), e); end
    Start_In = 1'b1; Mode_In = LOAD; Parallel_Data_In = 8'h00;
    edge_();
    e = {8'h97, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL shl3_e2_load_ignored got %h exp %h", obs(), e); end
    Start_In = 1'b0;
    edge_();
    e = {8'h2F, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL shl3_done got %h exp %h", obs(), e); end
    Mode_In = HOLD;
    edge_();
    e = {8'h2F, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL shl3_done_drop got %h exp %h", obs(), e); end
  endtask

  task automatic test_step_modes();
    logic [7:0] exp_seq [6];
    logic [2:0] modes [6];
    exp_seq = '{8'h96, 8'h2D, 8'h96, 8'hCB, 8'hE5, 8'hCA};
    modes   = '{LOAD, ROL, ROR, SHR, ASR, SHL};
    Parallel_Data_In = 8'h96; Serial_Left_In = 1'b1; Serial_Right_In = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Mode_In = modes[i];
      edge_();
      checks++;
      if (obs() !== {exp_seq[i], exp_seq[i][7], exp_seq[i][0], 2'b00}) begin
        errors++; $display("FAIL step_mode%0d got %h exp %h", i, obs(), {exp_seq[i], exp_seq[i][7], exp_seq[i][0], 2'b00});
      end
    end
    Mode_In = RSVD;
    edge_();
    checks++;
    if (obs() !== {8'hCA, 4'b1000}) begin errors++; $display("FAIL step_reserved got %h exp %h", obs(), {8'hCA, 4'b1000}); end
    Mode_In = LOAD; Start_In = 1'b1; Parallel_Data_In = 8'h3C;
    edge_();
    Start_In = 1'b0; Mode_In = HOLD;
    checks++;
    if (obs() !== {8'h3C, 4'b0001}) begin errors++; $display("FAIL start_load_done got %h exp %h", obs(), {8'h3C, 4'b0001}); end
  endtask

  task automatic run_ror(input logic [7:0] init, input logic [3:0] cnt, input logic [7:0] expv, input string nm);
    int dones;
    int busies;
    dones = 0; busies = 0;
    Mode_In = LOAD; Parallel_Data_In = init;
    edge_();
    Mode_In = ROR; Start_In = 1'b1; Shift_Count_In = cnt;
    for (int i = 0; i <= int'(cnt); i++) begin
      edge_();
      Start_In = 1'b0; Mode_In = HOLD;
      if (Done_Out === 1'b1) dones++;
      if (Busy_Out === 1'b1) busies++;
      if (i == int'(cnt) - 1) begin
        checks++;
        if (Parallel_Data_Out !== expv) begin errors++; $display("FAIL %s_data got %h exp %h", nm, Parallel_Data_Out, expv); end
      end
    end
    checks++;
    if (dones !== 1 || busies !== int'(cnt) - 1) begin
      errors++; $display("FAIL %s_status got done=%0d busy=%0d exp done=1 busy=%0d", nm, dones, busies, int'(cnt) - 1);
    end
  endtask

  task automatic test_ror_wrap();
    run_ror(8'h81, 4'd8, 8'h81, "ror8");
    run_ror(8'h01, 4'd9, 8'h80, "ror9");
  endtask

  task automatic test_asr_and_zero();
    Mode_In = LOAD; Parallel_Data_In = 8'h80;
    edge_();
    Mode_In = ASR; Start_In = 1'b1; Shift_Count_In = 4'd2;
    edge_();
    Start_In = 1'b0; Mode_In = HOLD;
    checks++;
    if (obs() !== {8'hC0, 4'b1010}) begin errors++; $display("FAIL asr2_e1 got %h exp %h", obs(), {8'hC0, 4'b1010}); end
    edge_();
    checks++;
    if (obs() !== {8'hE0, 4'b1001}) begin errors++; $display("FAIL asr2_done got %h exp %h", obs(), {8'hE0, 4'b1001}); end
    Mode_In = SHR; Start_In = 1'b1; Shift_Count_In = 4'd0; Serial_Left_In = 1'b0;
    edge_();
    Start_In = 1'b0; Mode_In = HOLD;
    checks++;
    if (obs() !== {8'hE0, 4'b1001}) begin errors++; $display("FAIL shr0_done got %h exp %h", obs(), {8'hE0, 4'b1001}); end
    edge_();
    checks++;
    if (obs() !== {8'hE0, 4'b1000}) begin errors++; $display("FAIL shr0_after got %h exp %h", obs(), {8'hE0, 4'b1000}); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] v;
    int bad;
    Mode_In = LOAD; Parallel_Data_In = 8'hFF;
    edge_();
    Mode_In = SHR; Start_In = 1'b1; Shift_Count_In = 4'd10; Serial_Left_In = 1'b0;
    v = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      edge_();
      Start_In = 1'b0; Mode_In = HOLD;
      v = {1'b0, v[7:1]};
    end
    checks++;
    if (obs() !== {v, v[7], v[0], 2'b10}) begin errors++; $display("FAIL shr10_e4 got %h exp %h", obs(), {v, v[7], v[0], 2'b10}); end
    #1 Reset_In = 1'b1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL abort_reset got %h exp %h", obs(), 12'h000); end
    #1 Reset_In = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      edge_();
      if (obs() !== 12'h000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d bad samples exp 0", bad); end
    Mode_In = SHL; Start_In = 1'b1; Shift_Count_In = 4'd2; Serial_Right_In = 1'b1;
    edge_();
    Start_In = 1'b0; Mode_In = HOLD;
    checks++;
    if (obs() !== {8'h01, 4'b0110}) begin errors++; $display("FAIL restart_e1 got %h exp %h", obs(), {8'h01, 4'b0110}); end
    edge_();
    checks++;
    if (obs() !== {8'h03, 4'b0101}) begin errors++; $display("FAIL restart_done got %h exp %h", obs(), {8'h03, 4'b0101}); end
  endtask

  task automatic test_enable_gap();
    logic [11:0] e;
    Mode_In = SHL; Start_In = 1'b1; Shift_Count_In = 4'd4; Serial_Right_In = 1'b0;
    edge_();
    Start_In = 1'b0; Mode_In = HOLD;
    edge_();
    checks++;
    if (obs() !== {8'h0C, 4'b0010}) begin errors++; $display("FAIL gap_e2 got %h exp %h", obs(), {8'h0C, 4'b0010}); end
    Enable_In = 1'b0; Mode_In = LOAD; Start_In = 1'b1; Parallel_Data_In = 8'hFF;
`ifdef USR_TRISTATE_OUTPUT_EN
    e = {8'hzz, 1'bz, 1'bz, 1'b1, 1'b0};
`else
    e = {8'h0C, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      edge_();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL gap_frozen%0d got %h exp %h", i, obs(), e); end
    end
    Enable_In = 1'b1; Mode_In = HOLD; Start_In = 1'b0;
    edge_();
    checks++;
    if (obs() !== {8'h18, 4'b0010}) begin errors++; $display("FAIL gap_resume1 got %h exp %h", obs(), {8'h18, 4'b0010}); end
    edge_();
    checks++;
    if (obs() !== {8'h30, 4'b0001}) begin errors++; $display("FAIL gap_done got %h exp %h", obs(), {8'h30, 4'b0001}); end
  endtask

  initial begin
    test_reset();
    test_shl3();
    test_step_modes();
    test_ror_wrap();
    test_asr_and_zero();
    test_reset_abort();
    test_enable_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
